// File: rtl/dezigzag_buffer.sv
// Purpose: ping-pong 2x64 coefficient buffer that reorders JPEG zigzag-ordered input into raster order.
// Latency: out_valid rises the cycle after the 64th coefficient of a block is accepted.
// Backpressure: in_ready drops while the bank being written is still full; outputs hold while out_ready is low.
// Ports: clk/rst (sync, active-high); in_data/in_valid/in_last/in_ready zigzag input side;
//        out_data/out_valid/out_last/out_ready raster output side; err sticky in_last mismatch flag.
module dezigzag_buffer #(
   parameter int DWIDTH = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              err
);

   // Zigzag index -> raster address.
   localparam logic [5:0] ZZ [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   // Two banks of 64 entries, addressed as {bank, raster index}. Not reset.
   logic [DWIDTH-1:0] bank_mem [0:127];

   logic [5:0] wr_idx_q, wr_idx_d;
   logic [5:0] rd_idx_q, rd_idx_d;
   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       err_q, err_d;

   logic       in_fire;
   logic       out_fire;
   logic       wr_at_end;
   logic       rd_at_end;
   logic [6:0] wr_addr;
   logic [6:0] rd_addr;

   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign wr_at_end = (wr_idx_q == 6'd63);
   assign rd_at_end = (rd_idx_q == 6'd63);
   assign wr_addr   = {wr_bank_q, ZZ[wr_idx_q]};
   assign rd_addr   = {rd_bank_q, rd_idx_q};

   // Read bank is never the write target while it is full, so the read
   // word stays stable across a stall without an output register.
   assign out_data  = out_valid ? bank_mem[rd_addr] : '0;
   assign out_last  = out_valid && rd_at_end;
   assign err       = err_q;

   always_comb begin
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      err_d     = err_q;

      if (in_fire) begin
         wr_idx_d = wr_idx_q + 6'd1;
         if (in_last != wr_at_end) begin
            err_d = 1'b1;
         end
         if (wr_at_end) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
      end

      // A write can only complete on a non-full bank and a read only on a
      // full one, so both full updates below always hit different banks.
      if (out_fire) begin
         rd_idx_d = rd_idx_q + 6'd1;
         if (rd_at_end) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && in_fire) begin
         bank_mem[wr_addr] <= in_data;
      end
   end

endmodule
